// File: rtl/cbus_mem_responder.sv
// cbus_mem_responder -- responder (slave) end of the cbus protocol, backed by
// an internal word-addressed 64-bit RAM model. It serves single- and multi-beat
// reads and writes (INCR or FIXED bursts, byte strobes) for cache fills and
// writebacks. It stands in for the SoC memory port in simulation benches.
//
// Optional build macro: CBUS_RANDOM_STALL_EN
//   When defined, a 16-bit Fibonacci LFSR inserts random bubbles into the beat
//   phase (ready held low). Beat count and data order are unchanged.
//
// Ports
//   clk    in   1            clock, all state updates on posedge
//   reset  in   1            synchronous active-low reset
//   creq   in   cbus_req_t   valid, is_write, size, addr, strobe, data, len, burst
//   cresp  out  cbus_resp_t  ready (beat complete), last (final beat), data
//
// Parameters
//   MEM_WORDS     depth of the RAM in 64-bit words (power of two)
//   READ_LATENCY  cycles from accept to first beat (1..15)
//   LFSR_SEED     stall LFSR seed (used only with CBUS_RANDOM_STALL_EN)

package cbus_pkg;
    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01
    } cbus_burst_e;

    typedef struct packed {
        logic        valid;
        logic        is_write;
        logic [2:0]  size;
        logic [63:0] addr;
        logic [7:0]  strobe;
        logic [63:0] data;
        logic [3:0]  len;
        cbus_burst_e burst;
    } cbus_req_t;

    typedef struct packed {
        logic        ready;
        logic        last;
        logic [63:0] data;
    } cbus_resp_t;
endpackage

module cbus_mem_responder
    import cbus_pkg::*;
#(
    parameter int          MEM_WORDS    = 4096,
    parameter int          READ_LATENCY = 2,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
    input  logic       clk,
    input  logic       reset,
    input  cbus_req_t  creq,
    output cbus_resp_t cresp
);

    localparam int IDX_W = $clog2(MEM_WORDS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_BEAT
    } state_e;

    state_e             state_q;
    logic [3:0]         cnt_q;
    logic [3:0]         beat_q;
    logic [3:0]         len_q;
    logic [IDX_W-1:0]   idx_q;
    logic               incr_q;
    logic               wr_q;
    logic               ready_q;
    logic               last_q;
    logic               stall_d;   // the coming cycle is a bubble

    logic [63:0]        mem [MEM_WORDS];

    // size and the address bits outside the word index play no part here.
    logic unused_req_bits;
    assign unused_req_bits = ^{creq.size, creq.addr[63:3+IDX_W], creq.addr[2:0]};

`ifdef CBUS_RANDOM_STALL_EN
    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;

    // Fibonacci LFSR, taps 16,14,13,11. stall_d looks at the value the LFSR
    // will hold next cycle so the registered ready lines up with it.
    always_comb begin
        lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign stall_d = lfsr_d[0];
`else
    assign stall_d = 1'b0;
`endif

    // Control FSM. ready_q/last_q are set on the edge that starts a beat
    // cycle, so they describe the cycle they are visible in.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_IDLE;
            ready_q <= 1'b0;
            last_q  <= 1'b0;
            cnt_q   <= '0;
            beat_q  <= '0;
            len_q   <= '0;
            idx_q   <= '0;
            incr_q  <= 1'b0;
            wr_q    <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    ready_q <= 1'b0;
                    last_q  <= 1'b0;
                    if (creq.valid) begin
                        idx_q   <= creq.addr[3+IDX_W-1:3];
                        len_q   <= creq.len;
                        incr_q  <= (creq.burst == BURST_INCR);
                        wr_q    <= creq.is_write;
                        beat_q  <= '0;
                        cnt_q   <= 4'(READ_LATENCY - 1);
                        state_q <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (cnt_q == 4'd0) begin
                        state_q <= S_BEAT;
                        ready_q <= !stall_d;
                        last_q  <= !stall_d && (len_q == 4'd0);
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                S_BEAT: begin
                    if (ready_q) begin
                        if (last_q) begin
                            state_q <= S_IDLE;
                            ready_q <= 1'b0;
                            last_q  <= 1'b0;
                        end else begin
                            beat_q  <= beat_q + 4'd1;
                            if (incr_q) begin
                                idx_q <= idx_q + 1'b1;   // wraps mod MEM_WORDS
                            end
                            ready_q <= !stall_d;
                            last_q  <= !stall_d && ((beat_q + 4'd1) == len_q);
                        end
                    end else begin
                        // bubble: index and beat count hold
                        ready_q <= !stall_d;
                        last_q  <= !stall_d && (beat_q == len_q);
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    ready_q <= 1'b0;
                    last_q  <= 1'b0;
                end
            endcase
        end
    end

    // Write beats take creq.data/strobe live in the ready cycle. The RAM is
    // never reset; a beat coinciding with reset is dropped with the transfer.
    always_ff @(posedge clk) begin
        if (reset && ready_q && wr_q) begin
            for (int k = 0; k < 8; k++) begin
                if (creq.strobe[k]) begin
                    mem[idx_q][8*k +: 8] <= creq.data[8*k +: 8];
                end
            end
        end
    end

    // Read data depends only on registered state; zero outside read beats.
    assign cresp.ready = ready_q;
    assign cresp.last  = last_q;
    assign cresp.data  = (ready_q && !wr_q) ? mem[idx_q] : 64'd0;

endmodule

// File: tb/tb_cbus_mem_responder.sv
module tb_cbus_mem_responder;
    import cbus_pkg::*;

    localparam int RL = 2;

    typedef logic [63:0] beats_t [16];

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    cbus_req_t  creq;
    cbus_resp_t cresp;

    int errors = 0;
    int checks = 0;

    beats_t wbuf;
    beats_t rbuf;
    int     nready, nlast, first_lat, span, wdata_nz;
    bit     tout;

    always #5 clk = ~clk;

    cbus_mem_responder #(
        .MEM_WORDS(4096),
        .READ_LATENCY(RL),
        .LFSR_SEED(16'hACE1)
    ) dut (
        .clk(clk),
        .reset(reset),
        .creq(creq),
        .cresp(cresp)
    );

    // Drives one transaction and records what the responder returned.
    task automatic xfer(input logic wr, input logic [63:0] addr, input logic [3:0] len,
                        input cbus_burst_e burst, input logic [7:0] strobe, input beats_t wd,
                        output beats_t rd, output int o_nready, output int o_nlast,
                        output int o_first, output int o_span, output int o_wnz,
                        output bit o_tout);
        int cyc;
        int b;
        for (int i = 0; i < 16; i++) rd[i] = '0;
        o_nready = 0; o_nlast = 0; o_first = -1; o_span = 0; o_wnz = 0; o_tout = 1'b0;
        cyc = 0; b = 0;
        @(negedge clk);
        creq.valid    = 1'b1;
        creq.is_write = wr;
        creq.size     = 3'd3;
        creq.addr     = addr;
        creq.len      = len;
        creq.burst    = burst;
        creq.strobe   = strobe;
        creq.data     = wd[0];
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (cresp.ready) begin
                if (o_first < 0) o_first = cyc;
                if (b < 16) begin
                    rd[b] = cresp.data;
                    creq.data = wd[b];
                end
                if (wr && cresp.data != 64'd0) o_wnz++;
                o_nready++;
                b++;
                if (cresp.last) begin
                    o_nlast++;
                    o_span = cyc;
                    break;
                end
            end else if (cresp.last) begin
                o_nlast++;
            end
            if (cyc > 200) begin
                o_tout = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
        creq.valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic write_word(input logic [63:0] addr, input logic [63:0] val);
        beats_t w;
        beats_t r;
        int a, c, d, e, f;
        bit t;
        for (int i = 0; i < 16; i++) w[i] = val;
        xfer(1'b1, addr, 4'd0, BURST_INCR, 8'hFF, w, r, a, c, d, e, f, t);
        checks++;
        if (t) begin
            errors++;
            $display("FAIL preload_timeout addr=%h got timeout, want completion", addr);
        end
    endtask

    task automatic test_reset();
        creq = '0;
        creq.valid = 1'b1;
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (cresp.ready !== 1'b0) begin
                errors++; $display("FAIL reset_ready cyc%0d got %b want 0", i, cresp.ready);
            end
            checks++;
            if (cresp.last !== 1'b0) begin
                errors++; $display("FAIL reset_last cyc%0d got %b want 0", i, cresp.last);
            end
            checks++;
            if (cresp.data !== 64'd0) begin
                errors++; $display("FAIL reset_data cyc%0d got %h want 0", i, cresp.data);
            end
        end
        @(negedge clk);
        reset = 1'b1;
        for (int i = 1; i <= RL + 1; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (i <= RL && cresp.ready !== 1'b0) begin
                errors++; $display("FAIL release_early_ready edge%0d got %b want 0", i, cresp.ready);
            end else if (i == RL + 1 && (cresp.ready !== 1'b1 || cresp.last !== 1'b1)) begin
                errors++;
                $display("FAIL release_first_beat edge%0d got ready=%b last=%b want 1/1",
                         i, cresp.ready, cresp.last);
            end
        end
        @(posedge clk);
        #1;
        creq.valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single_read();
        write_word(64'h10, 64'h1122334455667788);
        xfer(1'b0, 64'h10, 4'd0, BURST_INCR, 8'h00, wbuf, rbuf, nready, nlast, first_lat, span, wdata_nz, tout);
        checks++;
        if (tout || rbuf[0] !== 64'h1122334455667788) begin
            errors++; $display("FAIL single_read_data got %h want 1122334455667788", rbuf[0]);
        end
        checks++;
        if (nready != 1 || nlast != 1) begin
            errors++; $display("FAIL single_read_pulses got ready=%0d last=%0d want 1/1", nready, nlast);
        end
`ifndef CBUS_RANDOM_STALL_EN
        checks++;
        if (first_lat != RL + 1) begin
            errors++; $display("FAIL single_read_latency got %0d want %0d", first_lat, RL + 1);
        end
`endif
        // upper address bits alias onto the same word
        xfer(1'b0, 64'h8000_0000_0001_0010, 4'd0, BURST_INCR, 8'h00, wbuf, rbuf, nready, nlast,
             first_lat, span, wdata_nz, tout);
        checks++;
        if (tout || rbuf[0] !== 64'h1122334455667788) begin
            errors++; $display("FAIL alias_read got %h want 1122334455667788", rbuf[0]);
        end
    endtask

    task automatic test_incr_burst();
        logic [63:0] exp [4];
        exp[0] = 64'hA0A0_0000_0000_000A;
        exp[1] = 64'hB0B0_0000_0000_000B;
        exp[2] = 64'hC0C0_0000_0000_000C;
        exp[3] = 64'hD0D0_0000_0000_000D;
        for (int i = 0; i < 4; i++) write_word(64'h40 + 64'(8 * i), exp[i]);
        xfer(1'b0, 64'h40, 4'd3, BURST_INCR, 8'h00, wbuf, rbuf, nready, nlast, first_lat, span, wdata_nz, tout);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (tout || rbuf[i] !== exp[i]) begin
                errors++; $display("FAIL incr_beat%0d got %h want %h", i, rbuf[i], exp[i]);
            end
        end
        checks++;
        if (nready != 4 || nlast != 1) begin
            errors++; $display("FAIL incr_pulses got ready=%0d last=%0d want 4/1", nready, nlast);
        end
        checks++;
`ifdef CBUS_RANDOM_STALL_EN
        if (span <= RL + 4) begin
            errors++; $display("FAIL incr_bubble got span=%0d want >%0d", span, RL + 4);
        end
`else
        if (span != RL + 4) begin
            errors++; $display("FAIL incr_span got %0d want %0d", span, RL + 4);
        end
`endif
    endtask

    task automatic test_strobed_write();
        write_word(64'h28, 64'd0);
        wbuf[0] = 64'hFFFF_FFFF_DEAD_BEEF;
        xfer(1'b1, 64'h28, 4'd0, BURST_INCR, 8'h0F, wbuf, rbuf, nready, nlast, first_lat, span, wdata_nz, tout);
        checks++;
        if (tout || nready != 1 || nlast != 1) begin
            errors++; $display("FAIL strobe_write_pulses got ready=%0d last=%0d want 1/1", nready, nlast);
        end
        checks++;
        if (wdata_nz != 0) begin
            errors++; $display("FAIL strobe_write_respdata got %0d nonzero beats want 0", wdata_nz);
        end
        xfer(1'b0, 64'h28, 4'd0, BURST_INCR, 8'h00, wbuf, rbuf, nready, nlast, first_lat, span, wdata_nz, tout);
        checks++;
        if (tout || rbuf[0] !== 64'h0000_0000_DEAD_BEEF) begin
            errors++; $display("FAIL strobe_readback got %h want 00000000deadbeef", rbuf[0]);
        end
    endtask

    task automatic test_fixed_burst();
        write_word(64'h30, 64'h55);
        write_word(64'h38, 64'h77);
        wbuf[0] = 64'd1;
        wbuf[1] = 64'd2;
        xfer(1'b1, 64'h30, 4'd1, BURST_FIXED, 8'hFF, wbuf, rbuf, nready, nlast, first_lat, span, wdata_nz, tout);
        checks++;
        if (tout || nready != 2 || nlast != 1) begin
            errors++; $display("FAIL fixed_pulses got ready=%0d last=%0d want 2/1", nready, nlast);
        end
        xfer(1'b0, 64'h30, 4'd1, BURST_INCR, 8'h00, wbuf, rbuf, nready, nlast, first_lat, span, wdata_nz, tout);
        checks++;
        if (tout || rbuf[0] !== 64'd2) begin
            errors++; $display("FAIL fixed_ram6 got %h want 2", rbuf[0]);
        end
        checks++;
        if (rbuf[1] !== 64'h77) begin
            errors++; $display("FAIL fixed_ram7 got %h want 77", rbuf[1]);
        end
    endtask

    task automatic test_wrap();
        write_word(64'h7FF8, 64'hEEEE_0000_0000_0FFF);
        write_word(64'h0, 64'hFFFF_0000_0000_0000);
        xfer(1'b0, 64'h7FF8, 4'd1, BURST_INCR, 8'h00, wbuf, rbuf, nready, nlast, first_lat, span, wdata_nz, tout);
        checks++;
        if (tout || rbuf[0] !== 64'hEEEE_0000_0000_0FFF) begin
            errors++; $display("FAIL wrap_beat0 got %h want eeee000000000fff", rbuf[0]);
        end
        checks++;
        if (rbuf[1] !== 64'hFFFF_0000_0000_0000) begin
            errors++; $display("FAIL wrap_beat1 got %h want ffff000000000000", rbuf[1]);
        end
    endtask

    task automatic test_abort();
        int  cyc;
        bit  seen;
        seen = 1'b0;
        @(negedge clk);
        creq.valid = 1'b1; creq.is_write = 1'b0; creq.addr = 64'h40;
        creq.len = 4'd7; creq.burst = BURST_INCR; creq.strobe = 8'h00;
        for (cyc = 0; cyc < 50 && !seen; cyc++) begin
            @(posedge clk);
            #1;
            if (cresp.ready) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            errors++; $display("FAIL abort_first_beat got no ready in 50 cycles want ready");
        end
        reset = 1'b0;
        creq.valid = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (cresp.ready !== 1'b0 || cresp.last !== 1'b0) begin
            errors++; $display("FAIL abort_ready got ready=%b last=%b want 0/0", cresp.ready, cresp.last);
        end
        reset = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (cresp.ready !== 1'b0) begin
                errors++; $display("FAIL abort_idle cyc%0d got ready=%b want 0", i, cresp.ready);
            end
        end
        xfer(1'b0, 64'h10, 4'd0, BURST_INCR, 8'h00, wbuf, rbuf, nready, nlast, first_lat, span, wdata_nz, tout);
        checks++;
        if (tout || nready != 1 || rbuf[0] !== 64'h1122334455667788) begin
            errors++;
            $display("FAIL abort_recover got ready=%0d data=%h want 1/1122334455667788", nready, rbuf[0]);
        end
    endtask

    initial begin
        creq = '0;
        for (int i = 0; i < 16; i++) wbuf[i] = '0;
        test_reset();
        test_single_read();
        test_incr_burst();
        test_strobed_write();
        test_fixed_burst();
        test_wrap();
        test_abort();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
